tdc_hit_pattern_gen: RTL and testbench
======================================

// Module: tdc_hit_pattern_gen
// PURPOSE
//   Synthesisable multi-channel hit stimulus generator for on-chip TDC self-test and calibration.
//   Replaces hand-written hit sequences with programmable bursts of period-locked pulses.
//   Each channel has a programmable skew, so inter-channel delays are known.
//   Sits between the control/UART register block and the TDC hit inputs (muxed in during test mode).
// PARAMETERS
//   N_CH     4   number of hit channels
//   CNT_W    16  width of period, start-delay, burst-count and pulses_sent
//   PW_W     8   width of pulse-width and per-channel skew fields
// PORTS
//   clk            in   1           system clock, all logic on rising edge
//   rst            in   1           async active-high reset
//   start          in   1           1-cycle request; config sampled on the same edge
//   stop           in   1           abort request, level or pulse
//   cfg_period     in   CNT_W       period P in clocks
//   cfg_width      in   PW_W        pulse width W in clocks
//   cfg_start_dly  in   CNT_W       delay D in clocks before period 0
//   cfg_count      in   CNT_W       number of periods N; 0 = continuous until stop
//   cfg_ch_mask    in   N_CH        channel enable
//   cfg_skew       in   N_CH*PW_W   per-channel skew S_c; channel c at [c*PW_W +: PW_W]
//   hit            out  N_CH        registered hit outputs
//   busy           out  1           high in ARM or RUN
//   done           out  1           1-cycle pulse on completion or abort
//   aborted        out  1           set with done if terminated by stop; cleared on next accepted start
//   cfg_err        out  1           sticky config-error flag; cleared on next accepted start
//   pulses_sent    out  CNT_W       completed periods since last accepted start; wraps
// BEHAVIOUR
//   Reset (async): state=IDLE; hit=0, busy=0, done=0, aborted=0, cfg_err=0, pulses_sent=0.
//   States:
//     IDLE: start&!stop & valid config -> ARM. Latch config, clear aborted/cfg_err/pulses_sent.
//     ARM: counts D clocks -> RUN. D=0 means one cycle in ARM.
//     RUN: phase counter 0..P-1; wraps to 0 at P-1 and pulses_sent increments.
//     DONE_PULSE: one cycle with done=1 -> IDLE.
//   Config is invalid when:
//     - P==0 or W==0, or
//     - for any enabled c: S_c+W > P (computed at CNT_W+1 bits, no overflow).
//   Invalid start: cfg_err<=1, stay IDLE, no hits, no done.
//   Timing, taking the start edge as cycle 0:
//     - busy is high from cycle 1.
//     - Period k begins at cycle 2+D+k*P.
//     - hit[c] is high for cycles 2+D+k*P+S_c .. +S_c+W-1 when mask[c]=1; masked channels stay 0.
//   Termination with N>0:
//     - after period N-1 ends, pulses_sent==N and done=1 on the following cycle;
//     - busy drops in the same cycle that done rises.
//   Stop in ARM/RUN: next cycle hit=0, busy=0, done=1, aborted=1; pulses_sent holds.
//   Stop in IDLE has no effect. start&stop together in IDLE: stop wins, nothing starts.
//   start while busy or in DONE_PULSE: ignored. Config inputs are ignored except on an accepted start.
//   Continuous mode (N=0): runs until stop; pulses_sent wraps 2^CNT_W-1 -> 0.
//   Skew equal for two channels: simultaneous edges, same cycle.
//   Reset mid-burst: all outputs 0 asynchronously, no done.
// TESTING
//   1. P=20,W=3,D=0,N=1,mask=0001,S0=0: start@0 -> hit[0] high cycles 2-4; done@22; pulses_sent=1.
//   2. P=10,W=2,D=5,N=3,mask=1111,S={6,4,2,0}: start@0 -> hit[c] first rise @7+S_c, then every 10 clks;
//      done@37; pulses_sent=3.
//   3. P=8,W=4,S1=5,mask=0010 -> cfg_err=1, busy stays 0, hit stays 0.
//      Next valid start clears cfg_err.
//   4. N=0,P=4,W=1: stop after 10 periods -> hit=0 next cycle, done=1, aborted=1, pulses_sent=10.
//   5. start during RUN of test 2 -> ignored, timing unchanged.
//      start&stop together in IDLE -> no activity.
//   6. rst asserted mid-pulse in test 2 -> hit, busy, pulses_sent = 0 before the next edge; no done.
//      Normal start works afterwards.

Source files
------------

// File: rtl/tdc_hit_pattern_gen_if.sv
// Bus bundle for the TDC hit pattern generator: start/stop control, burst
// configuration, hit outputs and status.
interface tdc_hit_pattern_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int PW_W  = 8
) ();
    logic                   start;
    logic                   stop;
    logic [CNT_W-1:0]       cfg_period;
    logic [PW_W-1:0]        cfg_width;
    logic [CNT_W-1:0]       cfg_start_dly;
    logic [CNT_W-1:0]       cfg_count;
    logic [N_CH-1:0]        cfg_ch_mask;
    logic [N_CH*PW_W-1:0]   cfg_skew;

    logic [N_CH-1:0]        hit;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic                   cfg_err;
    logic [CNT_W-1:0]       pulses_sent;

    // Controller side (register block / test sequencer).
    modport master (
        output start, stop, cfg_period, cfg_width, cfg_start_dly, cfg_count,
               cfg_ch_mask, cfg_skew,
        input  hit, busy, done, aborted, cfg_err, pulses_sent
    );

    // Generator side.
    modport slave (
        input  start, stop, cfg_period, cfg_width, cfg_start_dly, cfg_count,
               cfg_ch_mask, cfg_skew,
        output hit, busy, done, aborted, cfg_err, pulses_sent
    );
endinterface

// File: rtl/tdc_hit_pattern_gen.sv
// Multi-channel hit stimulus generator for TDC self-test and calibration.
// Emits bursts of period-locked pulses with a programmable per-channel skew.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for an accepted start
//   ARM        | counting down the start delay (D+1 cycles, D=0 -> one cycle)
//   RUN        | phase counter 0..P-1 drives the hit windows
//   DONE_PULSE | single cycle with done=1, then back to IDLE
module tdc_hit_pattern_gen #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int PW_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    tdc_hit_pattern_gen_if.slave bus
);
    localparam int SW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE_PULSE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]     dly_q, dly_d;
    logic [CNT_W-1:0]     sent_q, sent_d;
    logic                 aborted_q, aborted_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [N_CH-1:0]      hit_q, hit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [CNT_W-1:0]     period_q;
    logic [PW_W-1:0]      width_q;
    logic [CNT_W-1:0]     count_q;
    logic [N_CH-1:0]      mask_q;
    logic [N_CH*PW_W-1:0] skew_q;

    logic                 cfg_ok;
    logic                 accept;

    // Config check: nonzero P and W, and every enabled window fits in the period.
    always_comb begin
        cfg_ok = (bus.cfg_period != '0) && (bus.cfg_width != '0);
        for (int c = 0; c < N_CH; c++) begin
            if (bus.cfg_ch_mask[c] &&
                ((SW'(bus.cfg_skew[c*PW_W +: PW_W]) + SW'(bus.cfg_width)) > SW'(bus.cfg_period)))
                cfg_ok = 1'b0;
        end
    end

    // stop takes priority over start in IDLE.
    assign accept = (state_q == IDLE) && bus.start && !bus.stop && cfg_ok;

    // Configuration is captured only on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            width_q  <= '0;
            count_q  <= '0;
            mask_q   <= '0;
            skew_q   <= '0;
        end else if (accept) begin
            period_q <= bus.cfg_period;
            width_q  <= bus.cfg_width;
            count_q  <= bus.cfg_count;
            mask_q   <= bus.cfg_ch_mask;
            skew_q   <= bus.cfg_skew;
        end
    end

    // Next-state, counters, and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dly_d     = dly_q;
        sent_d    = sent_q;
        aborted_d = aborted_q;
        cfg_err_d = cfg_err_q;
        hit_d     = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (cfg_ok) begin
                        state_d   = ARM;
                        dly_d     = bus.cfg_start_dly;
                        phase_d   = '0;
                        sent_d    = '0;
                        aborted_d = 1'b0;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ARM: begin
                if (bus.stop) begin
                    state_d   = DONE_PULSE;
                    aborted_d = 1'b1;
                end else if (dly_q == '0) begin
                    state_d = RUN;
                    phase_d = '0;
                end else begin
                    dly_d = dly_q - CNT_ONE;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d   = DONE_PULSE;
                    aborted_d = 1'b1;
                end else if (phase_q == period_q - CNT_ONE) begin
                    phase_d = '0;
                    sent_d  = sent_q + CNT_ONE;
                    // count==0 is continuous mode: never terminates on its own.
                    if ((count_q != '0) && (sent_q == count_q - CNT_ONE))
                        state_d = DONE_PULSE;
                end else begin
                    phase_d = phase_q + CNT_ONE;
                end
            end
            DONE_PULSE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Outputs are derived from the next state so the registers line up with it.
        busy_d = (state_d == ARM) || (state_d == RUN);
        done_d = (state_d == DONE_PULSE);
        for (int c = 0; c < N_CH; c++) begin
            hit_d[c] = (state_d == RUN) && mask_q[c] &&
                       (SW'(phase_d) >= SW'(skew_q[c*PW_W +: PW_W])) &&
                       (SW'(phase_d) <  SW'(skew_q[c*PW_W +: PW_W]) + SW'(width_q));
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            dly_q     <= '0;
            sent_q    <= '0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
            hit_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dly_q     <= dly_d;
            sent_q    <= sent_d;
            aborted_q <= aborted_d;
            cfg_err_q <= cfg_err_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.hit         = hit_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.pulses_sent = sent_q;
endmodule

// File: tb/tb_tdc_hit_pattern_gen.sv
// Bench for tdc_hit_pattern_gen. Cycle k is the clock period that ends with
// rising edge k; the edge sampling start is edge 0. Outputs are read on the
// falling edge inside the cycle they belong to.
module tb_tdc_hit_pattern_gen;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdc_hit_pattern_gen_if bus ();
    tdc_hit_pattern_gen dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Event-level model: records accepted starts / effective stops, outputs
    // are then closed-form functions of the cycle offset from the start edge.
    int edge_n = 0;
    bit m_has_run = 1'b0;
    int m_e0 = 0, m_tend = 0;
    int m_P = 1, m_W = 1, m_D = 0;
    bit m_stopped = 1'b0;
    bit m_cfg_err = 1'b0;
    logic [3:0] m_mask = '0;
    int m_S [4];

    function automatic bit cfg_valid(input int p, input int w, input logic [3:0] mask,
                                     input logic [31:0] skew);
        if (p == 0 || w == 0) return 1'b0;
        for (int c = 0; c < 4; c++)
            if (mask[c] && (int'(skew[c*8 +: 8]) + w > p)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_has_run <= 1'b0;
            m_cfg_err <= 1'b0;
            m_stopped <= 1'b0;
        end else begin
            edge_n <= edge_n + 1;
            if (bus.start && !bus.stop && (!m_has_run || (edge_n + 1 - m_e0) > m_tend)) begin
                if (cfg_valid(int'(bus.cfg_period), int'(bus.cfg_width), bus.cfg_ch_mask,
                              bus.cfg_skew)) begin
                    m_has_run <= 1'b1;
                    m_e0      <= edge_n + 1;
                    m_P       <= int'(bus.cfg_period);
                    m_W       <= int'(bus.cfg_width);
                    m_D       <= int'(bus.cfg_start_dly);
                    m_mask    <= bus.cfg_ch_mask;
                    for (int c = 0; c < 4; c++) m_S[c] <= int'(bus.cfg_skew[c*8 +: 8]);
                    m_tend    <= (bus.cfg_count == 0) ? BIG :
                                 2 + int'(bus.cfg_start_dly) + int'(bus.cfg_count) * int'(bus.cfg_period);
                    m_stopped <= 1'b0;
                    m_cfg_err <= 1'b0;
                end else begin
                    m_cfg_err <= 1'b1;
                end
            end else if (bus.stop && m_has_run && (edge_n + 1 - m_e0) >= 1 &&
                         (edge_n + 1 - m_e0) < m_tend) begin
                m_stopped <= 1'b1;
                m_tend    <= edge_n + 2 - m_e0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model on every cycle outside reset.
    always @(negedge clk) begin
        int rel, r, ph;
        logic [3:0] eh;
        logic eb, ed, ea;
        logic [15:0] es;
        eh = '0; eb = 1'b0; ed = 1'b0; ea = 1'b0; es = '0;
        if (!rst && chk_on) begin
            if (m_has_run) begin
                rel = edge_n - m_e0 + 1;
                eb  = (rel >= 1) && (rel < m_tend);
                ed  = (rel == m_tend);
                ea  = m_stopped && (rel >= m_tend);
                r   = m_stopped ? ((rel < m_tend - 1) ? rel : m_tend - 1)
                                : ((rel < m_tend) ? rel : m_tend);
                if (r >= 2 + m_D) es = 16'((r - 2 - m_D) / m_P);
                if (eb && rel >= 2 + m_D) begin
                    ph = (rel - 2 - m_D) % m_P;
                    for (int c = 0; c < 4; c++)
                        eh[c] = m_mask[c] && (ph >= m_S[c]) && (ph < m_S[c] + m_W);
                end
            end
            check("cmp_hit",     32'(bus.hit),         32'(eh));
            check("cmp_busy",    32'(bus.busy),        32'(eb));
            check("cmp_done",    32'(bus.done),        32'(ed));
            check("cmp_aborted", 32'(bus.aborted),     32'(ea));
            check("cmp_cfg_err", 32'(bus.cfg_err),     32'(m_cfg_err));
            check("cmp_sent",    32'(bus.pulses_sent), 32'(es));
        end
    end

    function automatic int cur_rel();
        return edge_n - m_e0 + 1;
    endfunction

    task automatic goto_rel(input int r);
        int guard;
        guard = 0;
        while (cur_rel() < r && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_rel timeout: at rel %0d, wanted %0d", cur_rel(), r);
        end
    endtask

    // Drive a one-cycle start (optionally with stop) from a falling edge.
    task automatic pulse_start(input int p, input int w, input int d, input int n,
                               input logic [3:0] mask, input logic [31:0] skew,
                               input logic stp);
        bus.cfg_period    = 16'(p);
        bus.cfg_width     = 8'(w);
        bus.cfg_start_dly = 16'(d);
        bus.cfg_count     = 16'(n);
        bus.cfg_ch_mask   = mask;
        bus.cfg_skew      = skew;
        bus.start         = 1'b1;
        bus.stop          = stp;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    localparam logic [31:0] SKEW_T2 = {8'd6, 8'd4, 8'd2, 8'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.cfg_period = '0; bus.cfg_width = '0; bus.cfg_start_dly = '0;
        bus.cfg_count = '0; bus.cfg_ch_mask = '0; bus.cfg_skew = '0;
        repeat (3) @(negedge clk);
        check("rst_hit",  32'(bus.hit), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_abrt", 32'(bus.aborted), 0);
        check("rst_cerr", 32'(bus.cfg_err), 0);
        check("rst_sent", 32'(bus.pulses_sent), 0);
        rst = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);

        // Single period, single channel.
        pulse_start(20, 3, 0, 1, 4'b0001, 32'd0, 1'b0);
        check("t1_busy1", 32'(bus.busy), 1);
        check("t1_hit1",  32'(bus.hit), 0);
        goto_rel(2);  check("t1_hit2", 32'(bus.hit), 1);
        goto_rel(4);  check("t1_hit4", 32'(bus.hit), 1);
        goto_rel(5);  check("t1_hit5", 32'(bus.hit), 0);
        goto_rel(21); check("t1_busy21", 32'(bus.busy), 1); check("t1_done21", 32'(bus.done), 0);
        goto_rel(22); check("t1_done22", 32'(bus.done), 1); check("t1_busy22", 32'(bus.busy), 0);
        check("t1_sent", 32'(bus.pulses_sent), 1);
        goto_rel(23); check("t1_done23", 32'(bus.done), 0);
        repeat (2) @(negedge clk);

        // Four skewed channels, start delay, three periods; ignored starts.
        pulse_start(10, 2, 5, 3, 4'hF, SKEW_T2, 1'b0);
        goto_rel(6);  check("t2_hit6",  32'(bus.hit), 4'b0000);
        goto_rel(7);  check("t2_hit7",  32'(bus.hit), 4'b0001);
        goto_rel(9);  check("t2_hit9",  32'(bus.hit), 4'b0010);
        goto_rel(11); check("t2_hit11", 32'(bus.hit), 4'b0100);
        goto_rel(13); check("t2_hit13", 32'(bus.hit), 4'b1000);
        goto_rel(17); check("t2_hit17", 32'(bus.hit), 4'b0001);
        goto_rel(20);
        pulse_start(3, 1, 0, 1, 4'b0001, 32'd0, 1'b0);
        goto_rel(23); check("t2_hit23", 32'(bus.hit), 4'b1000);
        goto_rel(37); check("t2_done37", 32'(bus.done), 1);
        check("t2_sent", 32'(bus.pulses_sent), 3);
        pulse_start(3, 1, 0, 1, 4'b0001, 32'd0, 1'b0);
        check("t2_nostart_done", 32'(bus.busy), 0);
        @(negedge clk);
        check("t2_nostart_b", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);

        // Config errors and the S+W==P boundary.
        pulse_start(8, 4, 0, 1, 4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, 1'b0);
        check("t3_err", 32'(bus.cfg_err), 1);
        repeat (3) @(negedge clk);
        check("t3_busy", 32'(bus.busy), 0);
        pulse_start(8, 4, 0, 1, 4'b0010, {8'd0, 8'd0, 8'd4, 8'd0}, 1'b0);
        check("t3_clr", 32'(bus.cfg_err), 0);
        goto_rel(6);  check("t3_hit6", 32'(bus.hit), 4'b0010);
        goto_rel(10); check("t3_done", 32'(bus.done), 1);
        goto_rel(12);
        pulse_start(0, 1, 0, 1, 4'b0001, 32'd0, 1'b0);
        check("t3_p0", 32'(bus.cfg_err), 1);
        pulse_start(8, 4, 0, 1, 4'b0001, {8'd0, 8'd0, 8'd5, 8'd0}, 1'b0);
        check("t3_masked_ok", 32'(bus.cfg_err), 0);
        goto_rel(11);
        pulse_start(8, 0, 0, 1, 4'b0001, 32'd0, 1'b0);
        check("t3_w0", 32'(bus.cfg_err), 1);
        repeat (2) @(negedge clk);

        // Continuous mode aborted after ten periods.
        pulse_start(4, 1, 0, 0, 4'b0001, 32'd0, 1'b0);
        goto_rel(42);
        check("t4_sent42", 32'(bus.pulses_sent), 10);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("t4_hit",  32'(bus.hit), 0);
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_done", 32'(bus.done), 1);
        check("t4_abrt", 32'(bus.aborted), 1);
        check("t4_sent", 32'(bus.pulses_sent), 10);
        goto_rel(46);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        pulse_start(4, 1, 0, 1, 4'b0001, 32'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("t5_idle_busy", 32'(bus.busy), 0);
        check("t5_idle_abrt", 32'(bus.aborted), 1);

        // Equal skews give simultaneous edges.
        pulse_start(5, 2, 1, 2, 4'hF, {8'd3, 8'd3, 8'd0, 8'd0}, 1'b0);
        goto_rel(3);  check("t7_hit3", 32'(bus.hit), 4'b0011);
        goto_rel(6);  check("t7_hit6", 32'(bus.hit), 4'b1100);
        goto_rel(8);  check("t7_hit8", 32'(bus.hit), 4'b0011);
        goto_rel(13); check("t7_done", 32'(bus.done), 1);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-pulse, then a normal run.
        pulse_start(10, 2, 5, 3, 4'hF, SKEW_T2, 1'b0);
        goto_rel(18);
        check("t6_hit18", 32'(bus.hit), 4'b0001);
        check("t6_sent18", 32'(bus.pulses_sent), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_hit",  32'(bus.hit), 0);
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_sent", 32'(bus.pulses_sent), 0);
        check("t6_rst_done", 32'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_done", 32'(bus.done), 0);
        pulse_start(20, 3, 0, 1, 4'b0001, 32'd0, 1'b0);
        goto_rel(2);  check("t6_hit2", 32'(bus.hit), 1);
        goto_rel(22); check("t6_done22", 32'(bus.done), 1);
        check("t6_sent", 32'(bus.pulses_sent), 1);
        repeat (2) @(negedge clk);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
